// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
//   General-purpose register file with a per-register busy scoreboard.
//   Decode reads two operands and reserves a destination; writeback writes
//   the result, which also releases the reservation.
//
// Ports
//   clk, rst                  rising-edge clock, async active-low reset
//   we, waddr, wdata          write port (always accepted, clears busy)
//   raddr_a, rdata_a, busy_a  read port A (combinational)
//   raddr_b, rdata_b, busy_b  read port B (combinational)
//   rsv_en, rsv_addr, rsv_ok  destination reservation request / grant
//
// Parameters
//   WIDTH, NREGS, ADDR_W      register width, register count, address width
//   BYPASS                    forward same-cycle write data to the read ports
//   ZERO_R0                   register 0 reads 0, ignores writes, never busy

// One register plus its busy flag.
module reg_file_scoreboard_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rsv_set,
  output logic [WIDTH-1:0] q,
  output logic             busy
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= '0;
      busy <= 1'b0;
    end else begin
      if (wr_en) q <= wdata;
      // A reservation landing with the releasing write keeps the register busy.
      if (rsv_set)    busy <= 1'b1;
      else if (wr_en) busy <= 1'b0;
    end
  end

endmodule

module reg_file_scoreboard #(
  parameter int WIDTH   = 16,
  parameter int NREGS   = 8,
  parameter int ADDR_W  = 3,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  output logic              busy_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              busy_b,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             busy;
  } rd_rsp_t;

  logic [NREGS-1:0][WIDTH-1:0] q;
  logic [NREGS-1:0]            busy_q;

  logic    wr_valid;
  logic    rsv_zero;
  logic    rsv_busy;
  logic    rsv_grant;
  rd_rsp_t rsp_a, rsp_b;

  // Writes to a missing register or to a hardwired-zero R0 never take effect
  // and are never forwarded.
  assign wr_valid = we && (int'(waddr) < NREGS) && !(ZERO_R0 && waddr == '0);

  // R0 under ZERO_R0 is always grantable and keeps no state.
  assign rsv_zero = ZERO_R0 && rsv_addr == '0;

  always_comb begin
    rsv_busy = 1'b0;
    for (int i = 0; i < NREGS; i++)
      if (rsv_addr == ADDR_W'(i)) rsv_busy = busy_q[i];
    // The write landing this cycle releases the register, so it is free now.
    if (wr_valid && waddr == rsv_addr) rsv_busy = 1'b0;
  end

  assign rsv_grant = rsv_en && (rsv_zero || (int'(rsv_addr) < NREGS && !rsv_busy));
  assign rsv_ok    = rst && rsv_grant;

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    if (ZERO_R0 && i == 0) begin : g_zero
      assign q[i]      = '0;
      assign busy_q[i] = 1'b0;
    end else begin : g_cell
      reg_file_scoreboard_cell #(.WIDTH(WIDTH)) u_cell (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_valid && waddr == ADDR_W'(i)),
        .wdata   (wdata),
        .rsv_set (rsv_grant && rsv_addr == ADDR_W'(i)),
        .q       (q[i]),
        .busy    (busy_q[i])
      );
    end
  end

  // Out-of-range addresses match no register and fall through to zero.
  function automatic rd_rsp_t read_port(input logic [ADDR_W-1:0] addr);
    rd_rsp_t r;
    r = '0;
    for (int i = 0; i < NREGS; i++)
      if (addr == ADDR_W'(i)) begin
        r.data = q[i];
        r.busy = busy_q[i];
      end
    if (BYPASS && wr_valid && waddr == addr) begin
      r.data = wdata;
      r.busy = 1'b0;
    end
    return r;
  endfunction

  // Outputs are held at zero for the whole reset window, including the
  // forwarded path.
  always_comb begin
    rsp_a = '0;
    rsp_b = '0;
    if (rst) begin
      rsp_a = read_port(raddr_a);
      rsp_b = read_port(raddr_b);
    end
  end

  assign rdata_a = rsp_a.data;
  assign busy_a  = rsp_a.busy;
  assign rdata_b = rsp_b.data;
  assign busy_b  = rsp_b.busy;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench. Two instances share all inputs:
//   d0: NREGS=8, BYPASS=1, ZERO_R0=0
//   d1: NREGS=6, BYPASS=0, ZERO_R0=1 (R6/R7 out of range)
module tb_reg_file_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [2:0]  raddr_a, raddr_b, rsv_addr;
  logic        rsv_en;

  logic [15:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
  logic        busy_a0, busy_b0, rsv_ok0, busy_a1, busy_b1, rsv_ok1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_scoreboard #(.WIDTH(16), .NREGS(8), .ADDR_W(3), .BYPASS(1'b1), .ZERO_R0(1'b0)) d0 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a0), .busy_a(busy_a0),
    .raddr_b(raddr_b), .rdata_b(rdata_b0), .busy_b(busy_b0),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok0)
  );

  reg_file_scoreboard #(.WIDTH(16), .NREGS(6), .ADDR_W(3), .BYPASS(1'b0), .ZERO_R0(1'b1)) d1 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a1), .busy_a(busy_a1),
    .raddr_b(raddr_b), .rdata_b(rdata_b1), .busy_b(busy_b1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int a = 0; a < 8; a++) begin
      raddr_a = 3'(a);
      raddr_b = 3'(7 - a);
      #1;
      chk({tag, " d0 rdata_a"}, rdata_a0, 0);
      chk({tag, " d0 busy_a"},  busy_a0,  0);
      chk({tag, " d0 rdata_b"}, rdata_b0, 0);
      chk({tag, " d0 busy_b"},  busy_b0,  0);
      chk({tag, " d1 rdata_a"}, rdata_a1, 0);
      chk({tag, " d1 busy_a"},  busy_a1,  0);
      chk({tag, " d1 rdata_b"}, rdata_b1, 0);
      chk({tag, " d1 busy_b"},  busy_b1,  0);
    end
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    raddr_a = '0; raddr_b = '0; rsv_en = 1'b1; rsv_addr = 3'd0;
    #2;
    // In reset: everything zero, even with a reserve request pending.
    chk_all_zero("in_reset");
    chk("in_reset d0 rsv_ok", rsv_ok0, 0);
    chk("in_reset d1 rsv_ok", rsv_ok1, 0);
    rsv_en = 1'b0;
    @(negedge clk) rst = 1'b1;
    step();
    chk_all_zero("after_reset");

    // Write R3; forwarded on d0 only, stored on both next cycle.
    we = 1; waddr = 3; wdata = 16'hA5A5; raddr_a = 3; #1;
    chk("wr3 bypass d0", rdata_a0, 16'hA5A5);
    chk("wr3 nobypass d1", rdata_a1, 16'h0000);
    step(); we = 0; #1;
    chk("rd3 d0", rdata_a0, 16'hA5A5);
    chk("rd3 d1", rdata_a1, 16'hA5A5);

    // Reserve R5, repeat rejected, write releases.
    rsv_en = 1; rsv_addr = 5; raddr_b = 5; #1;
    chk("rsv5 d0 ok", rsv_ok0, 1);
    chk("rsv5 d1 ok", rsv_ok1, 1);
    chk("rsv5 d0 busy before", busy_b0, 0);
    step(); #1;
    chk("rsv5 d0 busy", busy_b0, 1);
    chk("rsv5 d1 busy", busy_b1, 1);
    chk("rsv5 again d0 ok", rsv_ok0, 0);
    chk("rsv5 again d1 ok", rsv_ok1, 0);
    rsv_en = 0; we = 1; waddr = 5; wdata = 16'h0042; #1;
    chk("wr5 bypass d0 data", rdata_b0, 16'h0042);
    chk("wr5 bypass d0 busy", busy_b0, 0);
    chk("wr5 nobypass d1 data", rdata_b1, 16'h0000);
    chk("wr5 nobypass d1 busy", busy_b1, 1);
    step(); we = 0; #1;
    chk("rd5 d0 data", rdata_b0, 16'h0042);
    chk("rd5 d0 busy", busy_b0, 0);
    chk("rd5 d1 data", rdata_b1, 16'h0042);
    chk("rd5 d1 busy", busy_b1, 0);

    // Write and reserve R2 in the same cycle: reservation wins.
    we = 1; waddr = 2; wdata = 16'h1111; rsv_en = 1; rsv_addr = 2; raddr_a = 2; #1;
    chk("wr+rsv2 d0 ok", rsv_ok0, 1);
    chk("wr+rsv2 d1 ok", rsv_ok1, 1);
    chk("wr+rsv2 d0 bypass busy", busy_a0, 0);
    step(); we = 0; rsv_en = 0; #1;
    chk("r2 d0 data", rdata_a0, 16'h1111);
    chk("r2 d0 busy", busy_a0, 1);
    chk("r2 d1 data", rdata_a1, 16'h1111);
    chk("r2 d1 busy", busy_a1, 1);

    // R2 busy: bare reserve rejected; with a releasing write it is granted.
    rsv_en = 1; rsv_addr = 2; #1;
    chk("rsv2 busy d0 ok", rsv_ok0, 0);
    chk("rsv2 busy d1 ok", rsv_ok1, 0);
    we = 1; waddr = 2; wdata = 16'h2222; #1;
    chk("rsv2 eff d0 ok", rsv_ok0, 1);
    chk("rsv2 eff d1 ok", rsv_ok1, 1);
    chk("rsv2 eff d1 data", rdata_a1, 16'h1111);
    step(); we = 0; rsv_en = 0; #1;
    chk("r2b d0 data", rdata_a0, 16'h2222);
    chk("r2b d0 busy", busy_a0, 1);
    chk("r2b d1 data", rdata_a1, 16'h2222);
    chk("r2b d1 busy", busy_a1, 1);

    // R0: ordinary on d0, hardwired zero on d1.
    we = 1; waddr = 0; wdata = 16'hFFFF; rsv_en = 1; rsv_addr = 0; raddr_a = 0; #1;
    chk("r0 d0 ok", rsv_ok0, 1);
    chk("r0 d1 ok", rsv_ok1, 1);
    chk("r0 wr d0 bypass", rdata_a0, 16'hFFFF);
    chk("r0 wr d1 data", rdata_a1, 16'h0000);
    step(); we = 0; #1;
    chk("r0 d0 data", rdata_a0, 16'hFFFF);
    chk("r0 d0 busy", busy_a0, 1);
    chk("r0 d1 data", rdata_a1, 16'h0000);
    chk("r0 d1 busy", busy_a1, 0);
    chk("r0 again d0 ok", rsv_ok0, 0);
    chk("r0 again d1 ok", rsv_ok1, 1);
    rsv_en = 0;
    step();

    // Out of range on d1 (R6, R7).
    we = 1; waddr = 6; wdata = 16'hBEEF; rsv_en = 1; rsv_addr = 7; raddr_b = 6; #1;
    chk("oor d0 rsv7 ok", rsv_ok0, 1);
    chk("oor d1 rsv7 ok", rsv_ok1, 0);
    chk("oor d0 bypass r6", rdata_b0, 16'hBEEF);
    chk("oor d1 r6 data", rdata_b1, 16'h0000);
    step(); we = 0; rsv_en = 0; raddr_a = 7; #1;
    chk("oor d0 r6", rdata_b0, 16'hBEEF);
    chk("oor d1 r6", rdata_b1, 16'h0000);
    chk("oor d0 r7 busy", busy_a0, 1);
    chk("oor d1 r7 busy", busy_a1, 0);

    // Both ports on the same register.
    raddr_a = 3; raddr_b = 3; #1;
    chk("same d0 a", rdata_a0, 16'hA5A5);
    chk("same d0 b", rdata_b0, 16'hA5A5);
    chk("same d1 a", rdata_a1, 16'hA5A5);
    chk("same d1 b", rdata_b1, 16'hA5A5);

    // Reserve R1, write R4, then reset mid-cycle.
    rsv_en = 1; rsv_addr = 1; step(); rsv_en = 0;
    we = 1; waddr = 4; wdata = 16'h0BEE; step(); we = 0;
    raddr_a = 1; raddr_b = 4; #1;
    chk("pre_rst d0 busy1", busy_a0, 1);
    chk("pre_rst d1 busy1", busy_a1, 1);
    chk("pre_rst d0 r4", rdata_b0, 16'h0BEE);
    chk("pre_rst d1 r4", rdata_b1, 16'h0BEE);
    #1 rst = 1'b0; #1;
    chk("mid_rst d0 busy1", busy_a0, 0);
    chk("mid_rst d1 busy1", busy_a1, 0);
    chk("mid_rst d0 r4", rdata_b0, 16'h0000);
    chk("mid_rst d1 r4", rdata_b1, 16'h0000);
    @(negedge clk) rst = 1'b1;
    #1;
    chk_all_zero("post_mid_rst");
    rsv_en = 1; rsv_addr = 1; #1;
    chk("post_rst d0 rsv1 ok", rsv_ok0, 1);
    chk("post_rst d1 rsv1 ok", rsv_ok1, 1);
    rsv_en = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
